imm_extend_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the pipelined RV32/RV64 core. Decodes all base immediate formats (I, S, B, U, J) plus the CSR zero-extended uimm from a 32-bit instruction word, registers the result, and passes it downstream over a valid/ready handshake. A two-entry skid buffer gives a fully registered `In_Ready`, so the decode stage can stall without a combinational ready path.

---
 rtl/imm_extend_pipe.sv | 173 +++++++++++++++++
 tb/tb_imm_extend_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: decodes I/S/B/U/J/Z immediates from a 32-bit
// instruction word and hands them downstream through a two-entry skid buffer
// so that In_Ready is a flop output.
module imm_extend_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [31:0]     Instr,
  input  logic [2:0]      ImmSrc,
  input  logic            Flush,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [XLEN-1:0] Imm_Ext,
  output logic [2:0]      Imm_Fmt,
  output logic            Illegal
);

  localparam int unsigned IW = 32;
  localparam int unsigned FW = 3;

  localparam logic [FW-1:0] FMT_I = 3'b000;
  localparam logic [FW-1:0] FMT_S = 3'b001;
  localparam logic [FW-1:0] FMT_B = 3'b010;
  localparam logic [FW-1:0] FMT_U = 3'b011;
  localparam logic [FW-1:0] FMT_J = 3'b100;
  localparam logic [FW-1:0] FMT_Z = 3'b101;

  // One buffered entry: decoded immediate plus its format tag.
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [FW-1:0]   fmt;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  entry_t main_q;
  entry_t skid_q;
  entry_t dec_c;

  logic [IW-1:0] imm32_c;
  logic          ill_c;
  logic          accept_c;
  logic          xfer_c;
  logic          load_main_dec_c;
  logic          load_main_skid_c;
  logic          load_skid_c;

  // The opcode field carries no immediate bits in any format.
  logic unused_opcode;
  assign unused_opcode = ^Instr[6:0];

  // Assemble the 32-bit sign-extended immediate for the selected format.
  always_comb begin
    imm32_c = '0;
    ill_c   = 1'b0;
    case (ImmSrc)
      FMT_I:   imm32_c = {{20{Instr[31]}}, Instr[31:20]};
      FMT_S:   imm32_c = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      FMT_B:   imm32_c = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25],
                          Instr[11:8], 1'b0};
      FMT_U:   imm32_c = {Instr[31:12], 12'b0};
      FMT_J:   imm32_c = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20],
                          Instr[30:21], 1'b0};
      FMT_Z:   imm32_c = {27'b0, Instr[19:15]};
      default: ill_c   = 1'b1;
    endcase
  end

  // Widen to XLEN; Z has bit 31 clear, so sign extension also zero-extends it.
  always_comb begin
    dec_c     = '0;
    dec_c.imm = XLEN'($signed(imm32_c));
    dec_c.fmt = ImmSrc;
    dec_c.ill = ill_c;
  end

  assign accept_c = In_Valid && In_Ready;
  assign xfer_c   = Out_Valid && Out_Ready;

  // Next-state and storage-load decisions for the skid buffer.
  always_comb begin
    state_d          = state_q;
    load_main_dec_c  = 1'b0;
    load_main_skid_c = 1'b0;
    load_skid_c      = 1'b0;
    if (Flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept_c) begin
            state_d         = S_ONE;
            load_main_dec_c = 1'b1;
          end
        end
        S_ONE: begin
          if (accept_c && xfer_c) begin
            state_d         = S_ONE;
            load_main_dec_c = 1'b1;
          end else if (accept_c) begin
            state_d     = S_TWO;
            load_skid_c = 1'b1;
          end else if (xfer_c) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (xfer_c) begin
            state_d          = S_ONE;
            load_main_skid_c = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake flops; ready stays low through reset and for the full state.
  always_ff @(posedge clk) begin
    if (rst) begin
      In_Ready  <= 1'b0;
      Out_Valid <= 1'b0;
    end else begin
      In_Ready  <= (state_d != S_TWO);
      Out_Valid <= (state_d != S_EMPTY);
    end
  end

  // Main (output) register: fresh decode or promoted skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
    end else if (load_main_dec_c) begin
      main_q <= dec_c;
    end else if (load_main_skid_c) begin
      main_q <= skid_q;
    end
  end

  // Skid register catches the entry accepted while main is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q <= '0;
    end else if (load_skid_c) begin
      skid_q <= dec_c;
    end
  end

  assign Imm_Ext = main_q.imm;
  assign Imm_Fmt = main_q.fmt;
  assign Illegal = main_q.ill;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed scenarios plus random traffic against a
// queue-based reference model, with XLEN=32 and XLEN=64 instances in parallel.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        flush;
  logic        out_ready;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  int tests_run;
  int failed;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ref_t;

  ref_t mq[$];
  logic m_rdy;

  logic [31:0] sw_instr [5];
  logic [2:0]  sw_src   [5];
  logic [31:0] sw_exp   [5];

  imm_extend_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Ready(in_ready32),
    .Instr(instr), .ImmSrc(imm_src), .Flush(flush), .Out_Valid(out_valid32),
    .Out_Ready(out_ready), .Imm_Ext(imm32), .Imm_Fmt(fmt32), .Illegal(illegal32)
  );

  imm_extend_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Ready(in_ready64),
    .Instr(instr), .ImmSrc(imm_src), .Flush(flush), .Out_Valid(out_valid64),
    .Out_Ready(out_ready), .Imm_Ext(imm64), .Imm_Fmt(fmt64), .Illegal(illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Immediate value as a signed integer, 64-bit two's complement result.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s);
    longint v;
    v = 0;
    case (s)
      3'd0: begin v = longint'(w[31:20]); if (w[31]) v -= 4096; end
      3'd1: begin v = longint'({w[31:25], w[11:7]}); if (w[31]) v -= 4096; end
      3'd2: begin v = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}); if (w[31]) v -= 8192; end
      3'd3: begin v = longint'(w[31:12]) * 4096; if (w[31]) v -= 64'sd4294967296; end
      3'd4: begin v = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}); if (w[31]) v -= 2097152; end
      3'd5: v = longint'(w[19:15]);
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  // Advance the model by one edge using the current inputs, then clock the DUTs.
  task automatic tick();
    ref_t e;
    logic acc, xf;
    if (rst) begin
      mq.delete();
      m_rdy = 1'b0;
    end else begin
      acc = in_valid && m_rdy;
      xf  = (mq.size() > 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (xf) mq.delete(0);
        if (acc) begin
          e.imm = ref_imm(instr, imm_src);
          e.fmt = imm_src;
          e.ill = (imm_src > 3'd5);
          mq.push_back(e);
        end
      end
      m_rdy = (mq.size() < 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests_run++;
    if (out_valid32 !== 1'b0 || imm32 !== 32'h0 || fmt32 !== 3'd0 || illegal32 !== 1'b0 || in_ready32 !== 1'b0) begin
      failed++;
      $display("FAIL reset32: valid=%b imm=%h fmt=%0d ill=%b rdy=%b, expected all 0",
               out_valid32, imm32, fmt32, illegal32, in_ready32);
    end
    tests_run++;
    if (out_valid64 !== 1'b0 || imm64 !== 64'h0 || in_ready64 !== 1'b0) begin
      failed++;
      $display("FAIL reset64: valid=%b imm=%h rdy=%b, expected all 0", out_valid64, imm64, in_ready64);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1 || out_valid32 !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: rdy32=%b rdy64=%b valid=%b, expected 1 1 0",
               in_ready32, in_ready64, out_valid32);
    end
  endtask

  task automatic test_formats();
    sw_instr = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h800000B7, 32'h0000F073};
    sw_src   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    sw_exp   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000, 32'h00000001};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      instr    = sw_instr[i];
      imm_src  = sw_src[i];
      tick();
      tests_run++;
      if (out_valid32 !== 1'b1 || imm32 !== sw_exp[i] || fmt32 !== sw_src[i] || illegal32 !== 1'b0) begin
        failed++;
        $display("FAIL fmt_sweep[%0d]: valid=%b imm=%h fmt=%0d ill=%b, expected 1 %h %0d 0",
                 i, out_valid32, imm32, fmt32, illegal32, sw_exp[i], sw_src[i]);
      end
    end
    instr = 32'h800000B7; imm_src = 3'd3;
    tick();
    tests_run++;
    if (out_valid64 !== 1'b1 || imm64 !== 64'hFFFFFFFF80000000) begin
      failed++;
      $display("FAIL xlen64_u: valid=%b imm=%h, expected 1 ffffffff80000000", out_valid64, imm64);
    end
    instr = 32'h7FF00093; imm_src = 3'd0;
    tick();
    tests_run++;
    if (out_valid64 !== 1'b1 || imm64 !== 64'h00000000000007FF) begin
      failed++;
      $display("FAIL xlen64_i: valid=%b imm=%h, expected 1 00000000000007ff", out_valid64, imm64);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    imm_src   = 3'd0;
    in_valid  = 1'b1;
    instr     = 32'h00100093;
    tick();
    tests_run++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'd1 || in_ready32 !== 1'b1) begin
      failed++;
      $display("FAIL bp_accept_a: valid=%b imm=%h rdy=%b, expected 1 1 1", out_valid32, imm32, in_ready32);
    end
    instr = 32'h00200093;
    tick();
    tests_run++;
    if (in_ready32 !== 1'b0 || imm32 !== 32'd1) begin
      failed++;
      $display("FAIL bp_accept_b: rdy=%b imm=%h, expected 0 1", in_ready32, imm32);
    end
    instr = 32'h00300093;
    tick();
    tests_run++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || imm32 !== 32'd1) begin
      failed++;
      $display("FAIL bp_hold_c: rdy=%b valid=%b imm=%h, expected 0 1 1", in_ready32, out_valid32, imm32);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'd2) begin
      failed++;
      $display("FAIL bp_drain_b: valid=%b imm=%h, expected 1 2", out_valid32, imm32);
    end
    tick();
    tests_run++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'd3) begin
      failed++;
      $display("FAIL bp_drain_c: valid=%b imm=%h, expected 1 3", out_valid32, imm32);
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid32 !== 1'b0) begin
      failed++;
      $display("FAIL bp_empty: valid=%b, expected 0", out_valid32);
    end
  endtask

  task automatic test_flush_two();
    out_ready = 1'b0;
    imm_src   = 3'd0;
    in_valid  = 1'b1;
    instr     = 32'h00100093;
    tick();
    instr = 32'h00200093;
    tick();
    flush = 1'b1;
    instr = 32'h7FF00093;
    tick();
    tests_run++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
      failed++;
      $display("FAIL flush_two: valid=%b rdy=%b, expected 0 1", out_valid32, in_ready32);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_valid32 !== 1'b0) begin
        failed++;
        $display("FAIL flush_dropped[%0d]: valid=%b imm=%h, expected valid 0", i, out_valid32, imm32);
      end
    end
  endtask

  task automatic test_reserved();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    imm_src   = 3'b110;
    instr     = 32'hFFFFFFFF;
    tick();
    tests_run++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'h0 || illegal32 !== 1'b1 || fmt32 !== 3'b110 || imm64 !== 64'h0) begin
      failed++;
      $display("FAIL reserved: valid=%b imm=%h imm64=%h ill=%b fmt=%0d, expected 1 0 0 1 6",
               out_valid32, imm32, imm64, illegal32, fmt32);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_two();
    out_ready = 1'b0;
    imm_src   = 3'd4;
    in_valid  = 1'b1;
    instr     = 32'h8000006F;
    tick();
    instr = 32'h0010006F;
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (out_valid32 !== 1'b0 || imm32 !== 32'h0 || fmt32 !== 3'd0 || illegal32 !== 1'b0 ||
        in_ready32 !== 1'b0 || imm64 !== 64'h0) begin
      failed++;
      $display("FAIL reset_two: valid=%b imm=%h fmt=%0d ill=%b rdy=%b, expected all 0",
               out_valid32, imm32, fmt32, illegal32, in_ready32);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0) begin
      failed++;
      $display("FAIL reset_two_release: rdy=%b valid=%b, expected 1 0", in_ready32, out_valid32);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      instr     = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      tick();
      tests_run++;
      if (out_valid32 !== (mq.size() > 0) || in_ready32 !== m_rdy ||
          out_valid64 !== (mq.size() > 0) || in_ready64 !== m_rdy) begin
        failed++;
        $display("FAIL rand_hs[%0d]: v32=%b r32=%b v64=%b r64=%b, expected valid=%b rdy=%b",
                 c, out_valid32, in_ready32, out_valid64, in_ready64, mq.size() > 0, m_rdy);
      end
      if (mq.size() > 0) begin
        tests_run++;
        if (imm32 !== mq[0].imm[31:0] || fmt32 !== mq[0].fmt || illegal32 !== mq[0].ill ||
            imm64 !== mq[0].imm || fmt64 !== mq[0].fmt || illegal64 !== mq[0].ill) begin
          failed++;
          $display("FAIL rand_data[%0d]: imm32=%h imm64=%h fmt=%0d ill=%b, expected imm=%h fmt=%0d ill=%b",
                   c, imm32, imm64, fmt32, illegal32, mq[0].imm, mq[0].fmt, mq[0].ill);
        end
      end
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    m_rdy     = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = 32'h0;
    imm_src   = 3'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_formats();
    test_backpressure();
    test_flush_two();
    test_reserved();
    test_reset_in_two();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
